// File: rtl/memory_stage_lsu_pkg.sv
// Shared types for the memory-stage LSU: access encodings, FSM states, request payload.
// Optional feature macro used by the LSU: LSU_MISALIGN_TRAP_EN.
package memory_stage_lsu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned BE_W       = XLEN / 8;

    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b100,
        LT_LHU = 3'b101
    } Load_Type_Case;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } Store_Type_Case;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } Result_Mux_Case;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2
    } LSU_State_Case;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } Memory_Request;

    // Store lane enables and data replication; unlisted funct3 behaves as SW.
    function automatic Memory_Request store_request(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] addr,
                                                    input logic [XLEN-1:0] wdata);
        Memory_Request r;
        r.we   = 1'b1;
        r.addr = {addr[XLEN-1:2], 2'b00};
        case (funct3)
            ST_SB: begin
                r.be    = 4'b0001 << addr[1:0];
                r.wdata = {4{wdata[7:0]}};
            end
            ST_SH: begin
                r.be    = addr[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{wdata[15:0]}};
            end
            default: begin
                r.be    = 4'b1111;
                r.wdata = wdata;
            end
        endcase
        return r;
    endfunction

    function automatic Memory_Request load_request(input logic [XLEN-1:0] addr);
        Memory_Request r;
        r.we    = 1'b0;
        r.addr  = {addr[XLEN-1:2], 2'b00};
        r.wdata = '0;
        r.be    = 4'b1111;
        return r;
    endfunction

    function automatic logic access_misaligned(input logic       is_store,
                                               input logic [2:0] funct3,
                                               input logic [1:0] off);
        logic mis;
        if (is_store) begin
            case (funct3)
                ST_SB:   mis = 1'b0;
                ST_SH:   mis = off[0];
                default: mis = |off;
            endcase
        end else begin
            case (funct3)
                LT_LB, LT_LBU: mis = 1'b0;
                LT_LH, LT_LHU: mis = off[0];
                default:       mis = |off;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/memory_stage_lsu_load_data_align.sv
// Combinational load extraction: selects byte/half from the raw word and sign/zero-extends.
module load_data_align
    import memory_stage_lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      byte_off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = 8'h00;
        half_c = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (byte_off)
            2'd0:    byte_c = rdata[7:0];
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            default: byte_c = rdata[31:24];
        endcase
    end

    always_comb begin
        load_data_c = rdata;
        case (funct3)
            LT_LB:   load_data_c = {{24{byte_c[7]}}, byte_c};
            LT_LH:   load_data_c = {{16{half_c[15]}}, half_c};
            LT_LBU:  load_data_c = {24'h000000, byte_c};
            LT_LHU:  load_data_c = {16'h0000, half_c};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage_lsu.sv
// Memory stage LSU: accepts Execute ops, runs valid/ready data-memory accesses, emits the Writeback bundle.
// Define LSU_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on misalign.
module memory_stage_lsu
    import memory_stage_lsu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [XLEN-1:0]       ex_addr,
    input  logic [XLEN-1:0]       ex_wdata,
    input  logic [XLEN-1:0]       ex_pc4,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regw,
    input  logic [1:0]            ex_result_sel,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_we,
    output logic [XLEN-1:0]       dmem_req_addr,
    output logic [XLEN-1:0]       dmem_req_wdata,
    output logic [3:0]            dmem_req_be,
    input  logic                  dmem_rsp_valid,
    input  logic [XLEN-1:0]       dmem_rsp_rdata,
    output logic                  wb_valid,
    output logic [XLEN-1:0]       wb_alu_result,
    output logic [XLEN-1:0]       wb_mem_data,
    output logic [XLEN-1:0]       wb_pc4,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_regw,
    output logic [1:0]            wb_result_sel,
    output logic                  misalign
);

    localparam logic [1:0] S_IDLE     = LSU_IDLE;
    localparam logic [1:0] S_REQ      = LSU_REQ;
    localparam logic [1:0] S_WAIT_RSP = LSU_WAIT_RSP;

    logic [1:0]            state_q, state_d;
    logic                  ex_ready_q, ex_ready_d;
    logic                  req_valid_q, req_valid_d;
    Memory_Request         req_q, req_d;

    logic [2:0]            op_funct3_q, op_funct3_d;
    logic [1:0]            op_off_q, op_off_d;
    logic [XLEN-1:0]       op_alu_q, op_alu_d;
    logic [XLEN-1:0]       op_pc4_q, op_pc4_d;
    logic [REG_ADDR_W-1:0] op_rd_q, op_rd_d;
    logic                  op_regw_q, op_regw_d;
    logic [1:0]            op_sel_q, op_sel_d;

    logic                  wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]       wb_alu_q, wb_alu_d;
    logic [XLEN-1:0]       wb_mem_q, wb_mem_d;
    logic [XLEN-1:0]       wb_pc4_q, wb_pc4_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic                  wb_regw_q, wb_regw_d;
    logic [1:0]            wb_sel_q, wb_sel_d;
    logic                  misalign_q, misalign_d;

    logic                  accept_c;
    logic                  is_mem_c;
    logic                  misaligned_c;
    logic [XLEN-1:0]       load_data_c;

    load_data_align u_load_data_align (
        .rdata       (dmem_rsp_rdata),
        .byte_off    (op_off_q),
        .funct3      (op_funct3_q),
        .load_data_c (load_data_c)
    );

    always_comb begin
        accept_c = ex_valid & ex_ready_q;
        is_mem_c = ex_is_load | ex_is_store;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_c = is_mem_c & access_misaligned(ex_is_store, ex_funct3, ex_addr[1:0]);
`else
        misaligned_c = 1'b0;
`endif
    end

    // Next-state and output-register computation.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_d       = req_q;
        op_funct3_d = op_funct3_q;
        op_off_d    = op_off_q;
        op_alu_d    = op_alu_q;
        op_pc4_d    = op_pc4_q;
        op_rd_d     = op_rd_q;
        op_regw_d   = op_regw_q;
        op_sel_d    = op_sel_q;
        wb_valid_d  = 1'b0;
        wb_alu_d    = wb_alu_q;
        wb_mem_d    = wb_mem_q;
        wb_pc4_d    = wb_pc4_q;
        wb_rd_d     = wb_rd_q;
        wb_regw_d   = wb_regw_q;
        wb_sel_d    = wb_sel_q;
        misalign_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_funct3_d = ex_funct3;
                    op_off_d    = ex_addr[1:0];
                    op_alu_d    = ex_addr;
                    op_pc4_d    = ex_pc4;
                    op_rd_d     = ex_rd;
                    op_regw_d   = ex_regw;
                    op_sel_d    = ex_result_sel;
                    if (is_mem_c && !misaligned_c) begin
                        state_d     = S_REQ;
                        req_valid_d = 1'b1;
                        req_d       = ex_is_store ? store_request(ex_funct3, ex_addr, ex_wdata)
                                                  : load_request(ex_addr);
                    end else begin
                        // Pass-through (or trapped access): complete next cycle.
                        wb_valid_d = 1'b1;
                        wb_alu_d   = ex_addr;
                        wb_mem_d   = '0;
                        wb_pc4_d   = ex_pc4;
                        wb_rd_d    = ex_rd;
                        wb_regw_d  = ex_regw & ~misaligned_c;
                        wb_sel_d   = ex_result_sel;
                        misalign_d = misaligned_c;
                    end
                end
            end
            S_REQ: begin
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (req_q.we) begin
                        state_d    = S_IDLE;
                        wb_valid_d = 1'b1;
                        wb_alu_d   = op_alu_q;
                        wb_mem_d   = '0;
                        wb_pc4_d   = op_pc4_q;
                        wb_rd_d    = op_rd_q;
                        wb_regw_d  = 1'b0;
                        wb_sel_d   = op_sel_q;
                    end else begin
                        state_d = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_alu_d   = op_alu_q;
                    wb_mem_d   = load_data_c;
                    wb_pc4_d   = op_pc4_q;
                    wb_rd_d    = op_rd_q;
                    wb_regw_d  = op_regw_q;
                    wb_sel_d   = op_sel_q;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        ex_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ex_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            req_q       <= '0;
            op_funct3_q <= '0;
            op_off_q    <= '0;
            op_alu_q    <= '0;
            op_pc4_q    <= '0;
            op_rd_q     <= '0;
            op_regw_q   <= 1'b0;
            op_sel_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_alu_q    <= '0;
            wb_mem_q    <= '0;
            wb_pc4_q    <= '0;
            wb_rd_q     <= '0;
            wb_regw_q   <= 1'b0;
            wb_sel_q    <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_ready_q  <= ex_ready_d;
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            op_funct3_q <= op_funct3_d;
            op_off_q    <= op_off_d;
            op_alu_q    <= op_alu_d;
            op_pc4_q    <= op_pc4_d;
            op_rd_q     <= op_rd_d;
            op_regw_q   <= op_regw_d;
            op_sel_q    <= op_sel_d;
            wb_valid_q  <= wb_valid_d;
            wb_alu_q    <= wb_alu_d;
            wb_mem_q    <= wb_mem_d;
            wb_pc4_q    <= wb_pc4_d;
            wb_rd_q     <= wb_rd_d;
            wb_regw_q   <= wb_regw_d;
            wb_sel_q    <= wb_sel_d;
            misalign_q  <= misalign_d;
        end
    end

    assign ex_ready       = ex_ready_q;
    assign dmem_req_valid = req_valid_q;
    assign dmem_req_we    = req_q.we;
    assign dmem_req_addr  = req_q.addr;
    assign dmem_req_wdata = req_q.wdata;
    assign dmem_req_be    = req_q.be;
    assign wb_valid       = wb_valid_q;
    assign wb_alu_result  = wb_alu_q;
    assign wb_mem_data    = wb_mem_q;
    assign wb_pc4         = wb_pc4_q;
    assign wb_rd          = wb_rd_q;
    assign wb_regw        = wb_regw_q;
    assign wb_result_sel  = wb_sel_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed vector bench for memory_stage_lsu: table of single ops plus stall and reset sequences.
module tb_memory_stage_lsu;
    import memory_stage_lsu_pkg::*;

    logic        clk, reset;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata, ex_pc4;
    logic [4:0]  ex_rd;
    logic        ex_regw;
    logic [1:0]  ex_result_sel;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        wb_valid;
    logic [31:0] wb_alu_result, wb_mem_data, wb_pc4;
    logic [4:0]  wb_rd;
    logic        wb_regw;
    logic [1:0]  wb_result_sel;
    logic        misalign;

    int n_vec;
    int n_chk;
    int n_bad;

    memory_stage_lsu dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_pc4(ex_pc4), .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_result_sel(ex_result_sel),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_pc4(wb_pc4), .wb_rd(wb_rd), .wb_regw(wb_regw),
        .wb_result_sel(wb_result_sel), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic        exp_req;
        logic [31:0] exp_raddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_lat;
        logic        chk_mem;
        logic [31:0] exp_mem;
        logic        exp_regw;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic [1:0] sel,
                                input logic exp_req, input logic [31:0] raddr,
                                input logic [3:0] be, input logic [31:0] rwdata, input int lat,
                                input logic chk_mem, input logic [31:0] mem,
                                input logic regw, input logic mis);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.sel = sel; v.exp_req = exp_req; v.exp_raddr = raddr; v.exp_be = be;
        v.exp_wdata = rwdata; v.exp_lat = lat; v.chk_mem = chk_mem; v.exp_mem = mem;
        v.exp_regw = regw; v.exp_mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'b000;
        ex_addr = '0; ex_wdata = '0; ex_pc4 = '0; ex_rd = '0; ex_regw = 1'b0;
        ex_result_sel = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory responder: ready as soon as a request shows, read data the cycle after.
    task automatic run_vec(input vec_t v, input int idx);
        bit got_wb, req_seen, rsp_pending;
        got_wb = 0; req_seen = 0; rsp_pending = 0;
        n_vec++;
        ex_valid = 1'b1; ex_is_load = v.ld; ex_is_store = v.st; ex_funct3 = v.f3;
        ex_addr = v.addr; ex_wdata = v.wdata; ex_pc4 = 32'h1000 + 32'(idx * 4);
        ex_rd = 5'(idx + 1); ex_regw = 1'b1; ex_result_sel = v.sel;
        check($sformatf("v%0d_ex_ready", idx), 32'(ex_ready), 32'd1);
        tick();
        ex_idle();
        for (int c = 1; c <= 12 && !got_wb; c++) begin
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            if (rsp_pending) begin
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = v.rdata;
                rsp_pending = 0;
            end
            if (dmem_req_valid && !req_seen) begin
                req_seen = 1;
                check($sformatf("v%0d_req_valid", idx), 32'(dmem_req_valid), 32'(v.exp_req));
                check($sformatf("v%0d_req_addr", idx), dmem_req_addr, v.exp_raddr);
                check($sformatf("v%0d_req_we", idx), 32'(dmem_req_we), 32'(v.st));
                if (v.st) begin
                    check($sformatf("v%0d_req_be", idx), 32'(dmem_req_be), 32'(v.exp_be));
                    check($sformatf("v%0d_req_wdata", idx), dmem_req_wdata, v.exp_wdata);
                end
                dmem_req_ready = 1'b1;
                if (!dmem_req_we) rsp_pending = 1;
            end
            if (wb_valid) begin
                got_wb = 1;
                check($sformatf("v%0d_latency", idx), 32'(c), 32'(v.exp_lat));
                check($sformatf("v%0d_wb_regw", idx), 32'(wb_regw), 32'(v.exp_regw));
                check($sformatf("v%0d_wb_alu", idx), wb_alu_result, v.addr);
                check($sformatf("v%0d_wb_pc4", idx), wb_pc4, 32'h1000 + 32'(idx * 4));
                check($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(idx + 1));
                check($sformatf("v%0d_wb_sel", idx), 32'(wb_result_sel), 32'(v.sel));
                check($sformatf("v%0d_misalign", idx), 32'(misalign), 32'(v.exp_mis));
                if (v.chk_mem)
                    check($sformatf("v%0d_wb_mem", idx), wb_mem_data, v.exp_mem);
            end
            tick();
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        check($sformatf("v%0d_wb_seen", idx), 32'(got_wb), 32'd1);
        check($sformatf("v%0d_req_seen", idx), 32'(req_seen), 32'(v.exp_req));
        check($sformatf("v%0d_wb_pulse", idx), 32'(wb_valid), 32'd0);
    endtask

    initial begin
        n_vec = 0; n_chk = 0; n_bad = 0;
        clk = 1'b0;
        reset = 1'b1;
        ex_idle();
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;

        //         ld st f3      addr          wdata         rdata         sel      req raddr         be     rwdata        lat cm mem           rw mis
        vecs[0]  = mk(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        RES_ALU, 1, 32'h100, 4'hF, 32'hDEADBEEF, 2, 0, 32'h0,        0, 0);
        vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, RES_MEM, 1, 32'h100, 4'h0, 32'h0,        3, 1, 32'hFFFFFF80, 1, 0);
        vecs[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, RES_MEM, 1, 32'h100, 4'h0, 32'h0,        3, 1, 32'h00000080, 1, 0);
        vecs[3]  = mk(1, 0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, RES_MEM, 1, 32'h100, 4'h0, 32'h0,        3, 1, 32'h000080FF, 1, 0);
        vecs[4]  = mk(1, 0, 3'b001, 32'h100, 32'h0,        32'h12348765, RES_MEM, 1, 32'h100, 4'h0, 32'h0,        3, 1, 32'hFFFF8765, 1, 0);
        vecs[5]  = mk(1, 0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, RES_MEM, 1, 32'h104, 4'h0, 32'h0,        3, 1, 32'hCAFEF00D, 1, 0);
        vecs[6]  = mk(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0,        RES_ALU, 1, 32'h200, 4'h2, 32'hABABABAB, 2, 0, 32'h0,        0, 0);
        vecs[7]  = mk(0, 1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0,        RES_ALU, 1, 32'h200, 4'hC, 32'hBEEFBEEF, 2, 0, 32'h0,        0, 0);
        vecs[8]  = mk(0, 1, 3'b000, 32'h203, 32'h00000011, 32'h0,        RES_ALU, 1, 32'h200, 4'h8, 32'h11111111, 2, 0, 32'h0,        0, 0);
        vecs[9]  = mk(0, 1, 3'b011, 32'h300, 32'h0BADF00D, 32'h0,        RES_ALU, 1, 32'h300, 4'hF, 32'h0BADF00D, 2, 0, 32'h0,        0, 0);
        vecs[10] = mk(0, 0, 3'b000, 32'h55,  32'h0,        32'h0,        RES_ALU, 0, 32'h0,   4'h0, 32'h0,        1, 1, 32'h0,        1, 0);
        vecs[11] = mk(0, 0, 3'b000, 32'h66,  32'h0,        32'h0,        RES_PC4, 0, 32'h0,   4'h0, 32'h0,        1, 1, 32'h0,        1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = mk(1, 0, 3'b010, 32'h102, 32'h0,        32'h01020304, RES_MEM, 0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h0,        0, 1);
        vecs[13] = mk(0, 1, 3'b001, 32'h203, 32'h0000CAFE, 32'h0,        RES_ALU, 0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h0,        0, 1);
        vecs[14] = mk(1, 0, 3'b001, 32'h101, 32'h0,        32'hABCD8001, RES_MEM, 0, 32'h0,   4'h0, 32'h0,        1, 0, 32'h0,        0, 1);
`else
        vecs[12] = mk(1, 0, 3'b010, 32'h102, 32'h0,        32'h01020304, RES_MEM, 1, 32'h100, 4'h0, 32'h0,        3, 1, 32'h01020304, 1, 0);
        vecs[13] = mk(0, 1, 3'b001, 32'h203, 32'h0000CAFE, 32'h0,        RES_ALU, 1, 32'h200, 4'hC, 32'hCAFECAFE, 2, 0, 32'h0,        0, 0);
        vecs[14] = mk(1, 0, 3'b001, 32'h101, 32'h0,        32'hABCD8001, RES_MEM, 1, 32'h100, 4'h0, 32'h0,        3, 1, 32'hFFFF8001, 1, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++;
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_wb_mem", wb_mem_data, 32'd0);
        check("rst_wb_regw", 32'(wb_regw), 32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Three ALU ops on consecutive cycles: one wb pulse per op, one cycle behind.
        n_vec++;
        for (int k = 0; k < 3; k++) begin
            ex_valid = 1'b1; ex_addr = 32'h10 + 32'(k); ex_rd = 5'(20 + k); ex_regw = 1'b1;
            tick();
            check($sformatf("b2b%0d_wb_valid", k), 32'(wb_valid), 32'd1);
            check($sformatf("b2b%0d_wb_alu", k), wb_alu_result, 32'h10 + 32'(k));
            check($sformatf("b2b%0d_wb_rd", k), 32'(wb_rd), 32'(20 + k));
            check($sformatf("b2b%0d_req_valid", k), 32'(dmem_req_valid), 32'd0);
            check($sformatf("b2b%0d_ex_ready", k), 32'(ex_ready), 32'd1);
        end
        ex_idle();
        tick();
        check("b2b_end_wb_valid", 32'(wb_valid), 32'd0);

        // Stalled load: ready low 3 cycles, early rsp ignored, held ALU op waits for IDLE.
        n_vec++;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h600;
        ex_rd = 5'd7; ex_regw = 1'b1; ex_result_sel = 2'b01;
        tick();
        ex_is_load = 1'b0; ex_addr = 32'h77; ex_rd = 5'd9; ex_result_sel = 2'b00;
        for (int k = 0; k < 3; k++) begin
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hBADBAD00;
            check($sformatf("stall%0d_req_valid", k), 32'(dmem_req_valid), 32'd1);
            check($sformatf("stall%0d_req_addr", k), dmem_req_addr, 32'h600);
            check($sformatf("stall%0d_req_we", k), 32'(dmem_req_we), 32'd0);
            check($sformatf("stall%0d_ex_ready", k), 32'(ex_ready), 32'd0);
            check($sformatf("stall%0d_wb_valid", k), 32'(wb_valid), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b0;
        check("stall_req_hold", 32'(dmem_req_valid), 32'd1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        check("stall_wait_ex_ready", 32'(ex_ready), 32'd0);
        check("stall_wait_req_valid", 32'(dmem_req_valid), 32'd0);
        check("stall_wait_wb_valid", 32'(wb_valid), 32'd0);
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h600DF00D;
        tick();
        dmem_rsp_valid = 1'b0;
        check("stall_ld_wb_valid", 32'(wb_valid), 32'd1);
        check("stall_ld_wb_mem", wb_mem_data, 32'h600DF00D);
        check("stall_ld_wb_rd", 32'(wb_rd), 32'd7);
        check("stall_ld_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        ex_idle();
        check("stall_alu_wb_valid", 32'(wb_valid), 32'd1);
        check("stall_alu_wb_alu", wb_alu_result, 32'h77);
        check("stall_alu_wb_rd", 32'(wb_rd), 32'd9);
        tick();
        check("stall_end_wb_valid", 32'(wb_valid), 32'd0);

        // Reset while waiting for a load response; the late response must be dropped.
        n_vec++;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h500;
        ex_rd = 5'd3; ex_regw = 1'b1;
        tick();
        ex_idle();
        check("rstw_req_valid", 32'(dmem_req_valid), 32'd1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        check("rstw_in_wait", 32'(ex_ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw_ex_ready", 32'(ex_ready), 32'd1);
        check("rstw_req_valid_after", 32'(dmem_req_valid), 32'd0);
        dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h12345678;
        tick();
        dmem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstw_late%0d_wb_valid", k), 32'(wb_valid), 32'd0);
            check($sformatf("rstw_late%0d_ex_ready", k), 32'(ex_ready), 32'd1);
            tick();
        end
        check("rstw_wb_mem", wb_mem_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
